// File: rtl/mem_1r1w_masked_fwd.sv
// mem_1r1w_masked_fwd: single-clock 1R1W memory with per-lane write masks,
// same-cycle write-to-read forwarding, per-lane valid tracking (so unwritten
// lanes read as zero after reset) and an optional output register.
//
// Read handshake: a read is requested by R0_en=1 on a rising edge. Exactly
// 1+OUT_REG edges later R0_valid is high for one cycle per request, and
// R0_data carries that request's result. R0_data holds its last value
// while R0_valid=0. There is no back-pressure, so one read per cycle is
// always accepted.
module mem_1r1w_masked_fwd #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int OUT_REG   = 0,
  localparam int NLANES   = WIDTH / MASK_GRAN,
  localparam int ADDR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [NLANES-1:0] W0_mask
);

  // DEPTH always fits in ADDR_W+1 bits, which also covers power-of-two depths.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem        [DEPTH];
  logic [NLANES-1:0] lane_valid [DEPTH];

  logic             rd_in_range;
  logic             wr_in_range;
  logic             fwd_hit;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;

  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_W);
  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_W);
  // Equal addresses with an in-range read imply an in-range write.
  assign fwd_hit     = W0_en && (W0_addr == R0_addr);

  // Per-lane read word: forwarded write lane, else stored lane if valid, else zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      for (int i = 0; i < NLANES; i++) begin
        if (fwd_hit && W0_mask[i]) begin
          rd_word[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
        end else if (lane_valid[R0_addr][i]) begin
          rd_word[i*MASK_GRAN +: MASK_GRAN] = mem[R0_addr][i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Storage array: masked lane writes, never reset.
  always_ff @(posedge clock) begin
    if (W0_en && wr_in_range) begin
      for (int i = 0; i < NLANES; i++) begin
        if (W0_mask[i]) begin
          mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Lane-valid bits: cleared by reset, set by each masked lane write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        lane_valid[d] <= '0;
      end
    end else if (W0_en && wr_in_range) begin
      lane_valid[W0_addr] <= lane_valid[W0_addr] | W0_mask;
    end
  end

  // Read stage 1: capture the read word on a request, hold data otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= R0_en;
      if (R0_en) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;

      // Read stage 2: register stage-1 data only when it carries a result.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign R0_data  = s2_data;
      assign R0_valid = s2_valid;
    end else begin : g_no_out_reg
      assign R0_data  = s1_data;
      assign R0_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mem_1r1w_masked_fwd.sv
// tb_mem_1r1w_masked_fwd: drives one shared stimulus stream into two
// instances -- dut_a (32 words, latency 1) and dut_b (20 words, OUT_REG=1,
// latency 2) -- and compares both against a lane-level reference model.
module tb_mem_1r1w_masked_fwd;

  localparam int W  = 64;
  localparam int NL = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [4:0]    r_addr;
  logic          r_en;
  logic [4:0]    w_addr;
  logic          w_en;
  logic [W-1:0]  w_data;
  logic [NL-1:0] w_mask;
  logic [W-1:0]  data_a, data_b;
  logic          valid_a, valid_b;

  mem_1r1w_masked_fwd dut_a (
    .clock(clock), .reset(reset),
    .R0_addr(r_addr), .R0_en(r_en), .R0_data(data_a), .R0_valid(valid_a),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
  );

  mem_1r1w_masked_fwd #(.DEPTH(20), .OUT_REG(1)) dut_b (
    .clock(clock), .reset(reset),
    .R0_addr(r_addr), .R0_en(r_en), .R0_data(data_b), .R0_valid(valid_b),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
  );

  // ---------------- reference model ----------------
  // Word contents and per-lane written flags; a lane reads as zero until written.
  logic [W-1:0]  mm [32];
  logic [NL-1:0] mv [32];
  logic          exp_va, exp_vb;
  logic [W-1:0]  exp_da, exp_db;
  logic          pend_v;          // dut_b read issued one edge ago
  logic [W-1:0]  pend_d;
  int            checks, errors;

  function automatic logic [W-1:0] model_read(input logic [4:0] ra, input int depth,
                                              input logic we, input logic [4:0] wa,
                                              input logic [W-1:0] wd, input logic [NL-1:0] wm);
    logic [W-1:0] r;
    r = '0;
    if (int'(ra) < depth) begin
      for (int i = 0; i < NL; i++) begin
        if (we && wa == ra && wm[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        else if (mv[ra][i])          r[i*8 +: 8] = mm[ra][i*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 32; d++) mv[d] = '0;
    exp_va = 1'b0; exp_vb = 1'b0;
    exp_da = '0;   exp_db = '0;
    pend_v = 1'b0; pend_d = '0;
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of stimulus, wait for the edge, then advance the model.
  task automatic step(input logic re, input logic [4:0] ra, input logic we,
                      input logic [4:0] wa, input logic [W-1:0] wd, input logic [NL-1:0] wm);
    logic [W-1:0] res_a, res_b;
    r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd; w_mask = wm;
    res_a = model_read(ra, 32, we, wa, wd, wm);
    res_b = model_read(ra, 20, we, wa, wd, wm);
    @(posedge clock);
    #1;
    if (we) begin
      for (int i = 0; i < NL; i++) begin
        if (wm[i]) begin
          mm[wa][i*8 +: 8] = wd[i*8 +: 8];
          mv[wa][i] = 1'b1;
        end
      end
    end
    exp_va = re;
    if (re) exp_da = res_a;
    exp_vb = pend_v;
    if (pend_v) exp_db = pend_d;
    pend_v = re;
    if (re) pend_d = res_b;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step(1'b1, 5'd5, 1'b1, 5'd5, {W{1'b1}}, '1);
    model_reset();
    repeat (2) begin
      checks++;
      if ({valid_a, data_a} !== {1'b0, {W{1'b0}}}) begin
        errors++; $display("FAIL reset port_a: got %0b/%h expected 0/0", valid_a, data_a);
      end
      checks++;
      if ({valid_b, data_b} !== {1'b0, {W{1'b0}}}) begin
        errors++; $display("FAIL reset port_b: got %0b/%h expected 0/0", valid_b, data_b);
      end
      @(posedge clock); #1;
    end
    r_en = 1'b0; w_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_unwritten();
    step(1'b1, 5'd5, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h0) begin
      errors++; $display("FAIL unwritten port_a: got %0b/%h expected 1/0", valid_a, data_a);
    end
    checks++;
    if (valid_b !== 1'b0) begin
      errors++; $display("FAIL unwritten_early port_b: got valid %0b expected 0", valid_b);
    end
    idle();
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'h0) begin
      errors++; $display("FAIL unwritten port_b: got %0b/%h expected 1/0", valid_b, data_b);
    end
    checks++;
    if (valid_a !== 1'b0 || data_a !== 64'h0) begin
      errors++; $display("FAIL unwritten_hold port_a: got %0b/%h expected 0/0", valid_a, data_a);
    end
  endtask

  task automatic test_masked_write();
    step(1'b0, 5'd0, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF);
    step(1'b1, 5'd3, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h1122334455667788) begin
      errors++; $display("FAIL full_write port_a: got %0b/%h expected 1/1122334455667788", valid_a, data_a);
    end
    step(1'b0, 5'd0, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h01);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'h1122334455667788) begin
      errors++; $display("FAIL full_write port_b: got %0b/%h expected 1/1122334455667788", valid_b, data_b);
    end
    step(1'b1, 5'd3, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h11223344556677AA) begin
      errors++; $display("FAIL lane_write port_a: got %0b/%h expected 1/11223344556677aa", valid_a, data_a);
    end
    idle();
    checks++;
    if ({valid_b, data_b} !== {exp_vb, exp_db}) begin
      errors++; $display("FAIL lane_write port_b: got %0b/%h expected %0b/%h", valid_b, data_b, exp_vb, exp_db);
    end
  endtask

  task automatic test_partial_after_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    r_en = 1'b0; w_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 5'd0, 1'b1, 5'd7, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    step(1'b1, 5'd7, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h00000000FFFFFFFF) begin
      errors++; $display("FAIL partial port_a: got %0b/%h expected 1/00000000ffffffff", valid_a, data_a);
    end
    idle();
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'h00000000FFFFFFFF) begin
      errors++; $display("FAIL partial port_b: got %0b/%h expected 1/00000000ffffffff", valid_b, data_b);
    end
  endtask

  task automatic test_forwarding();
    step(1'b0, 5'd0, 1'b1, 5'd9, 64'h0, 8'hFF);
    step(1'b1, 5'd9, 1'b1, 5'd9, 64'hDEADBEEFCAFEF00D, 8'hF0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'hDEADBEEF00000000) begin
      errors++; $display("FAIL forward port_a: got %0b/%h expected 1/deadbeef00000000", valid_a, data_a);
    end
    // A write right after the read must not disturb dut_b's in-flight result.
    step(1'b1, 5'd9, 1'b1, 5'd9, 64'h0123456789ABCDEF, 8'hFF);
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'hDEADBEEF00000000) begin
      errors++; $display("FAIL forward port_b: got %0b/%h expected 1/deadbeef00000000", valid_b, data_b);
    end
    checks++;
    if ({valid_a, data_a} !== {exp_va, exp_da}) begin
      errors++; $display("FAIL forward_next port_a: got %0b/%h expected %0b/%h", valid_a, data_a, exp_va, exp_da);
    end
    step(1'b1, 5'd9, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL reread port_a: got %0b/%h expected 1/0123456789abcdef", valid_a, data_a);
    end
    idle();
    checks++;
    if ({valid_b, data_b} !== {exp_vb, exp_db}) begin
      errors++; $display("FAIL reread port_b: got %0b/%h expected %0b/%h", valid_b, data_b, exp_vb, exp_db);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    for (int a = 0; a < 20; a++) step(1'b0, 5'(a), 1'b1, 5'(a), {$urandom, $urandom}, 8'hFF);
    step(1'b0, 5'd0, 1'b1, 5'd25, {$urandom, $urandom}, 8'hFF);
    step(1'b1, 5'd25, 1'b0, 5'd0, '0, '0);
    idle();
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'h0) begin
      errors++; $display("FAIL out_of_range port_b: got %0b/%h expected 1/0", valid_b, data_b);
    end
    pulses = 0;
    for (int j = 0; j < 22; j++) begin
      if (j < 20) step(1'b1, 5'(j), 1'b0, 5'd0, '0, '0);
      else        idle();
      if (valid_b === 1'b1 && j >= 1 && j <= 20) pulses++;
      checks++;
      if ({valid_a, data_a} !== {exp_va, exp_da}) begin
        errors++; $display("FAIL b2b port_a cycle %0d: got %0b/%h expected %0b/%h", j, valid_a, data_a, exp_va, exp_da);
      end
      checks++;
      if ({valid_b, data_b} !== {exp_vb, exp_db}) begin
        errors++; $display("FAIL b2b port_b cycle %0d: got %0b/%h expected %0b/%h", j, valid_b, data_b, exp_vb, exp_db);
      end
    end
    checks++;
    if (pulses !== 20) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected 20", pulses);
    end
  endtask

  task automatic test_random();
    logic [4:0] ra, wa;
    for (int n = 0; n < 400; n++) begin
      ra = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
           {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      checks++;
      if ({valid_a, data_a} !== {exp_va, exp_da}) begin
        errors++; $display("FAIL random port_a cycle %0d: got %0b/%h expected %0b/%h", n, valid_a, data_a, exp_va, exp_da);
      end
      checks++;
      if ({valid_b, data_b} !== {exp_vb, exp_db}) begin
        errors++; $display("FAIL random port_b cycle %0d: got %0b/%h expected %0b/%h", n, valid_b, data_b, exp_vb, exp_db);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 5'd0, 1'b1, 5'd12, 64'h5A5A_0F0F_C3C3_9696, 8'hFF);
    step(1'b1, 5'd12, 1'b0, 5'd0, '0, '0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({valid_a, data_a} !== {1'b0, {W{1'b0}}}) begin
      errors++; $display("FAIL midreset port_a: got %0b/%h expected 0/0", valid_a, data_a);
    end
    checks++;
    if ({valid_b, data_b} !== {1'b0, {W{1'b0}}}) begin
      errors++; $display("FAIL midreset port_b: got %0b/%h expected 0/0", valid_b, data_b);
    end
    r_en = 1'b0; w_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      idle();
      checks++;
      if ({valid_b, data_b} !== {1'b0, {W{1'b0}}}) begin
        errors++; $display("FAIL dropped_read port_b cycle %0d: got %0b/%h expected 0/0", j, valid_b, data_b);
      end
    end
    step(1'b1, 5'd12, 1'b0, 5'd0, '0, '0);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 64'h0) begin
      errors++; $display("FAIL masked_after_reset port_a: got %0b/%h expected 1/0", valid_a, data_a);
    end
    idle();
    checks++;
    if (valid_b !== 1'b1 || data_b !== 64'h0) begin
      errors++; $display("FAIL masked_after_reset port_b: got %0b/%h expected 1/0", valid_b, data_b);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0; errors = 0;
    r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
    test_reset();
    test_unwritten();
    test_masked_write();
    test_partial_after_reset();
    test_forwarding();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
